parity_frame_rx: RTL and testbench

Serial frame receiver: deserializes start/data/parity/stop frames from a one-bit line, recomputes parity with an XOR reduction, and presents each received word through a valid/ready output with a one-entry holding register. It is the receiving end of the team's parity-protected serial link. It sits between the line sampler, which supplies one `bit_en` strobe per bit period, and any consumer of parallel words.

---
 rtl/parity_frame_rx_pkg.sv | 20 ++
 rtl/parity_frame_rx_if.sv | 20 ++
 rtl/parity_frame_rx_hold_reg.sv | 69 ++++++
 rtl/parity_frame_rx.sv | 95 +++++++++
 tb/tb_parity_frame_rx.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared definitions for the parity-protected serial link: receiver states,
// data width bounds and the parity helper shared with the transmitter.
package parity_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned DATA_W_MIN = 1;
    localparam int unsigned DATA_W_MAX = 16;

    // Parity bit that makes the frame's total count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_of(input logic [DATA_W_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_frame_rx_if.sv
// Valid/ready word output of the frame receiver; master is the receiver side.
interface parity_frame_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_parity_err;
    logic              out_frame_err;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data, out_parity_err, out_frame_err, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_parity_err, out_frame_err, out_valid,
        output out_ready
    );
endinterface

// File: rtl/parity_frame_rx_hold_reg.sv
// One-entry valid/ready holding register; a commit into a full, unaccepted
// entry is dropped and raises the sticky overrun flag.
module rx_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              perr_i,
    input  logic              ferr_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              valid_o,
    output logic              overrun_o
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              load;

    always_comb begin
        load      = commit_i && (!valid_q || ready_i);
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            data_d  = data_i;
            perr_d  = perr_i;
            ferr_d  = ferr_i;
            valid_d = 1'b1;
        end else begin
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
            if (commit_i) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign perr_o    = perr_q;
    assign ferr_o    = ferr_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start/data(LSB first)/parity/stop, advancing only on
// bit_en strobes, delivering each word through a one-entry holding register.
module parity_frame_rx
    import parity_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_en,
    input  logic                  rx_bit,
    parity_frame_rx_if.master     out_if,
    output logic                  overrun
);
    localparam int unsigned CNT_W = $clog2(DATA_W_MAX + 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              perr_q, perr_d;
    logic              commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        perr_d  = perr_q;
        commit  = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                DATA: begin
                    // Right-shifting from the MSB lands bit cnt at position cnt after DATA_W bits.
                    shift_d = (shift_q >> 1) | (DATA_W'(rx_bit) << (DATA_W - 1));
                    acc_d   = acc_q ^ rx_bit;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = acc_q ^ rx_bit ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            perr_q  <= perr_d;
        end
    end

    rx_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .commit_i  (commit),
        .data_i    (shift_q),
        .perr_i    (perr_q),
        .ferr_i    (~rx_bit),
        .ready_i   (out_if.out_ready),
        .data_o    (out_if.out_data),
        .perr_o    (out_if.out_parity_err),
        .ferr_o    (out_if.out_frame_err),
        .valid_o   (out_if.out_valid),
        .overrun_o (overrun)
    );
endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: table of frames plus hand-written
// sequences for overrun, glitchy strobes, mid-frame reset and odd parity.
module tb_parity_frame_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_en = 1'b0;
    logic rx_bit = 1'b1;
    logic rdy = 1'b0;
    logic ovr_e, ovr_o;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_frame_rx_if #(.DATA_W(8)) e_if ();
    parity_frame_rx_if #(.DATA_W(8)) o_if ();
    assign e_if.out_ready = rdy;
    assign o_if.out_ready = rdy;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit),
        .out_if(e_if), .overrun(ovr_e)
    );
    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit),
        .out_if(o_if), .overrun(ovr_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       sbit;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int g = 1; g < gap; g++) begin
            bit_en = 1'b0;
            rx_bit = 1'($urandom % 2);
            cyc();
        end
        bit_en = 1'b1;
        rx_bit = b;
        cyc();
        bit_en = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic p, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
        send_head(d, p, gap);
        send_bit(s, gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic accept();
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        check("reset_valid", 32'(e_if.out_valid), 32'd0);
        check("reset_data", 32'(e_if.out_data), 32'd0);
        check("reset_perr", 32'(e_if.out_parity_err), 32'd0);
        check("reset_ferr", 32'(e_if.out_frame_err), 32'd0);
        check("reset_overrun", 32'(ovr_e), 32'd0);

        for (int v = 0; v < 8; v++) begin
            send_head(vecs[v].data, vecs[v].pbit, 1);
            check("valid_before_stop", 32'(e_if.out_valid), 32'd0);
            send_bit(vecs[v].sbit, 1);
            check("tbl_valid", 32'(e_if.out_valid), 32'd1);
            check("tbl_data", 32'(e_if.out_data), 32'(vecs[v].data));
            check("tbl_perr", 32'(e_if.out_parity_err), 32'(vecs[v].exp_perr));
            check("tbl_ferr", 32'(e_if.out_frame_err), 32'(vecs[v].exp_ferr));
            repeat (3) cyc();
            check("hold_valid", 32'(e_if.out_valid), 32'd1);
            check("hold_data", 32'(e_if.out_data), 32'(vecs[v].data));
            accept();
            check("accept_valid", 32'(e_if.out_valid), 32'd0);
            check("tbl_overrun", 32'(ovr_e), 32'd0);
        end

        send_frame(8'hFF, 1'b0, 1'b1, 4);
        check("glitch_valid", 32'(e_if.out_valid), 32'd1);
        check("glitch_data", 32'(e_if.out_data), 32'hFF);
        check("glitch_perr", 32'(e_if.out_parity_err), 32'd0);
        check("glitch_ferr", 32'(e_if.out_frame_err), 32'd0);
        accept();

        send_frame(8'h3C, 1'b0, 1'b1, 1);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        check("ovr_data", 32'(e_if.out_data), 32'h3C);
        check("ovr_valid", 32'(e_if.out_valid), 32'd1);
        check("ovr_flag", 32'(ovr_e), 32'd1);

        // Mid-frame reset with a full holding register and sticky overrun set.
        send_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
        do_reset();
        check("mrst_valid", 32'(e_if.out_valid), 32'd0);
        check("mrst_data", 32'(e_if.out_data), 32'd0);
        check("mrst_overrun", 32'(ovr_e), 32'd0);
        check("mrst_perr", 32'(e_if.out_parity_err), 32'd0);
        send_frame(8'h12, 1'b0, 1'b1, 2);
        check("mrst_new_data", 32'(e_if.out_data), 32'h12);
        check("mrst_new_valid", 32'(e_if.out_valid), 32'd1);
        check("mrst_new_perr", 32'(e_if.out_parity_err), 32'd0);
        check("mrst_new_ferr", 32'(e_if.out_frame_err), 32'd0);

        do_reset();
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        send_head(8'h81, 1'b0, 1);
        rdy = 1'b1;
        send_bit(1'b1, 1);
        rdy = 1'b0;
        check("swap_data", 32'(e_if.out_data), 32'h81);
        check("swap_valid", 32'(e_if.out_valid), 32'd1);
        check("swap_overrun", 32'(ovr_e), 32'd0);
        accept();

        do_reset();
        send_frame(8'h00, 1'b1, 1'b1, 1);
        check("odd_p1_perr", 32'(o_if.out_parity_err), 32'd0);
        check("even_p1_perr", 32'(e_if.out_parity_err), 32'd1);
        check("odd_p1_valid", 32'(o_if.out_valid), 32'd1);
        accept();
        send_frame(8'h00, 1'b0, 1'b1, 1);
        check("odd_p0_perr", 32'(o_if.out_parity_err), 32'd1);
        check("even_p0_perr", 32'(e_if.out_parity_err), 32'd0);
        check("odd_p0_data", 32'(o_if.out_data), 32'd0);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
